// File: rtl/sd_spi_byte.sv
// SPI mode-0 byte exchanger for the SD card: MSB-first shift out/in, SCK idles low,
// plus ownership of the card chip-select line.
module sd_spi_byte #(
  parameter int unsigned DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] senddata,
  output logic       rdy,
  output logic [7:0] recvdata,
  input  logic       cs_wr,
  input  logic       cs_val,
  output logic       sd_clk,
  output logic       sd_do,
  input  logic       sd_di,
  output logic       sd_cs_n
);

  localparam int unsigned   DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    state_q,     state_d;
  logic [DW-1:0] divcnt_q,    divcnt_d;
  logic [2:0]    bitcnt_q,    bitcnt_d;
  logic [7:0]    shift_out_q, shift_out_d;
  logic [7:0]    shift_in_q,  shift_in_d;
  logic [7:0]    recvdata_q,  recvdata_d;
  logic          sd_clk_q,    sd_clk_d;
  logic          sd_cs_n_q,   sd_cs_n_d;

  always_comb begin
    state_d     = state_q;
    divcnt_d    = divcnt_q;
    bitcnt_d    = bitcnt_q;
    shift_out_d = shift_out_q;
    shift_in_d  = shift_in_q;
    recvdata_d  = recvdata_q;
    sd_clk_d    = sd_clk_q;
    sd_cs_n_d   = sd_cs_n_q;

    case (state_q)
      S_IDLE: begin
        if (cs_wr) begin
          sd_cs_n_d = cs_val;
        end
        if (start) begin
          state_d     = S_BUSY;
          shift_out_d = senddata;
          bitcnt_d    = '0;
          divcnt_d    = '0;
          sd_clk_d    = 1'b0;
        end
      end
      S_BUSY: begin
        if (divcnt_q != DIV_LAST) begin
          divcnt_d = divcnt_q + 1'b1;
        end else begin
          divcnt_d = '0;
          if (!sd_clk_q) begin
            sd_clk_d = 1'b1;
          end else begin
            // Falling SCK edge: sample MISO and present the next MOSI bit together.
            sd_clk_d    = 1'b0;
            shift_in_d  = {shift_in_q[6:0], sd_di};
            shift_out_d = {shift_out_q[6:0], 1'b0};
            bitcnt_d    = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              recvdata_d = {shift_in_q[6:0], sd_di};
              bitcnt_d   = '0;
              state_d    = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      divcnt_q    <= '0;
      bitcnt_q    <= '0;
      shift_out_q <= '0;
      shift_in_q  <= '0;
      recvdata_q  <= '1;
      sd_clk_q    <= 1'b0;
      sd_cs_n_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      divcnt_q    <= divcnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_out_q <= shift_out_d;
      shift_in_q  <= shift_in_d;
      recvdata_q  <= recvdata_d;
      sd_clk_q    <= sd_clk_d;
      sd_cs_n_q   <= sd_cs_n_d;
    end
  end

  assign rdy      = (state_q == S_IDLE);
  assign recvdata = recvdata_q;
  assign sd_clk   = sd_clk_q;
  assign sd_do    = (state_q == S_BUSY) ? shift_out_q[7] : 1'b1;
  assign sd_cs_n  = sd_cs_n_q;

endmodule

// File: tb/tb_sd_spi_byte.sv
// Bench for sd_spi_byte: one instance at DIV=2 and one at DIV=1, each checked every
// cycle against a timeline model derived from the cycle offset since start.
module tb_sd_spi_byte;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_s  [2];
  logic [7:0] send_s   [2];
  logic       rdy_s    [2];
  logic [7:0] recv_s   [2];
  logic       cs_wr_s  [2];
  logic       cs_val_s [2];
  logic       sclk_s   [2];
  logic       sdo_s    [2];
  logic       sdi_s    [2];
  logic       csn_s    [2];

  sd_spi_byte #(.DIV(2)) u_div2 (
    .clk(clk), .rst(rst), .start(start_s[0]), .senddata(send_s[0]), .rdy(rdy_s[0]),
    .recvdata(recv_s[0]), .cs_wr(cs_wr_s[0]), .cs_val(cs_val_s[0]), .sd_clk(sclk_s[0]),
    .sd_do(sdo_s[0]), .sd_di(sdi_s[0]), .sd_cs_n(csn_s[0])
  );

  sd_spi_byte #(.DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .senddata(send_s[1]), .rdy(rdy_s[1]),
    .recvdata(recv_s[1]), .cs_wr(cs_wr_s[1]), .cs_val(cs_val_s[1]), .sd_clk(sclk_s[1]),
    .sd_do(sdo_s[1]), .sd_di(sdi_s[1]), .sd_cs_n(csn_s[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int divof(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Model: busy flag plus cycle offset k (1..16*DIV) into the exchange.
  logic       m_valid = 1'b0;
  logic       m_busy [2];
  int         m_k    [2];
  logic [7:0] m_send [2];
  logic [7:0] m_ret  [2];
  logic [7:0] m_recv [2];
  logic       m_cs   [2];
  logic [7:0] card   [2];
  logic       noise = 1'b0;

  always @(posedge clk) begin
    m_valid <= 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] <= 1'b0;
        m_k[d]    <= 0;
        m_recv[d] <= 8'hFF;
        m_cs[d]   <= 1'b1;
      end else if (!m_busy[d]) begin
        if (start_s[d]) begin
          m_busy[d] <= 1'b1;
          m_k[d]    <= 1;
          m_send[d] <= send_s[d];
          m_ret[d]  <= card[d];
        end
        if (cs_wr_s[d]) m_cs[d] <= cs_val_s[d];
      end else if (m_k[d] == 16 * divof(d)) begin
        m_busy[d] <= 1'b0;
        m_recv[d] <= m_ret[d];
      end else begin
        m_k[d] <= m_k[d] + 1;
      end
    end
  end

  // Card: presents bit i of its byte (MSB first) for the whole of bit period i.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      sdi_s[d] = noise;
      if (m_busy[d] === 1'b1)
        sdi_s[d] = m_ret[d][7 - (m_k[d] - 1) / (2 * divof(d))];
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int d = 0; d < 2; d++) begin
        int   bit_i;
        logic e_clk, e_do;
        bit_i = (m_k[d] - 1) / (2 * divof(d));
        e_clk = m_busy[d] ? 1'(((m_k[d] - 1) / divof(d)) % 2) : 1'b0;
        e_do  = m_busy[d] ? m_send[d][7 - bit_i] : 1'b1;
        chk($sformatf("rdy%0d", d),     rdy_s[d],  !m_busy[d]);
        chk($sformatf("sd_clk%0d", d),  sclk_s[d], e_clk);
        chk($sformatf("sd_do%0d", d),   sdo_s[d],  e_do);
        chk($sformatf("recv%0d", d),    recv_s[d], m_recv[d]);
        chk($sformatf("sd_cs_n%0d", d), csn_s[d],  m_cs[d]);
      end
    end
  end

  // MOSI captured at each SCK rise on the DIV=2 instance.
  logic       prev0   = 1'b0;
  logic [7:0] cap0    = 8'h00;
  int         pulses0 = 0;
  always @(negedge clk) begin
    if (sclk_s[0] === 1'b1 && !prev0) begin
      cap0    <= {cap0[6:0], sdo_s[0]};
      pulses0 <= pulses0 + 1;
    end
    prev0 <= (sclk_s[0] === 1'b1);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
      noise = 1'($urandom);
    end
  endtask

  task automatic strobe_start(input int d, input logic [7:0] send, input logic [7:0] ret);
    card[d]    = ret;
    send_s[d]  = send;
    start_s[d] = 1'b1;
    cyc(1);
    start_s[d] = 1'b0;
    send_s[d]  = 8'($urandom);
  endtask

  // Counts rdy=0 cycles; optionally fires random start/cs_wr strobes that must be ignored.
  task automatic wait_rdy(input int d, input bit noisy, output int low);
    low = 0;
    for (int i = 0; i < 700 && rdy_s[d] !== 1'b1; i++) begin
      if (noisy) begin
        start_s[d]  = ($urandom_range(0, 3) == 0);
        send_s[d]   = 8'($urandom);
        cs_wr_s[d]  = ($urandom_range(0, 3) == 0);
        cs_val_s[d] = 1'($urandom);
      end
      low++;
      cyc(1);
    end
    start_s[d] = 1'b0;
    cs_wr_s[d] = 1'b0;
    chk("rdy_timeout", rdy_s[d], 1'b1);
  endtask

  initial begin
    int low, p0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; send_s[d] = 8'h00; cs_wr_s[d] = 1'b0; cs_val_s[d] = 1'b0;
      card[d] = 8'h00;
    end
    cyc(3);
    rst = 1'b0;
    chk("reset_rdy",  rdy_s[0], 1'b1);
    chk("reset_recv", recv_s[0], 8'hFF);
    chk("reset_sclk", sclk_s[0], 1'b0);
    chk("reset_sdo",  sdo_s[0], 1'b1);
    chk("reset_csn",  csn_s[0], 1'b1);

    // 1: select card, exchange A5 <-> 3C
    cs_wr_s[0] = 1'b1; cs_val_s[0] = 1'b0;
    cyc(1);
    cs_wr_s[0] = 1'b0;
    chk("t1_csn", csn_s[0], 1'b0);
    p0 = pulses0;
    strobe_start(0, 8'hA5, 8'h3C);
    wait_rdy(0, 1'b0, low);
    chk("t1_low",    low, 32);
    chk("t1_recv",   recv_s[0], 8'h3C);
    chk("t1_mosi",   cap0, 8'hA5);
    chk("t1_pulses", pulses0 - p0, 8);

    // 2: second start at T+5 is ignored
    strobe_start(0, 8'hA5, 8'h99);
    cyc(4);
    send_s[0] = 8'h00; start_s[0] = 1'b1;
    cyc(1);
    start_s[0] = 1'b0;
    wait_rdy(0, 1'b0, low);
    chk("t2_low",  low + 5, 32);
    chk("t2_mosi", cap0, 8'hA5);

    // 3: back-to-back start in first rdy=1 cycle
    strobe_start(0, 8'hFF, 8'hFE);
    chk("t3_rdy_drop", rdy_s[0], 1'b0);
    wait_rdy(0, 1'b0, low);
    chk("t3_low",  low, 32);
    chk("t3_recv", recv_s[0], 8'hFE);
    cyc(5);
    chk("t2_no_second", rdy_s[0], 1'b1);

    // 4: reset at bit 4
    strobe_start(0, 8'h5A, 8'h11);
    cyc(16);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t4_rdy",  rdy_s[0], 1'b1);
    chk("t4_recv", recv_s[0], 8'hFF);
    chk("t4_sclk", sclk_s[0], 1'b0);
    chk("t4_sdo",  sdo_s[0], 1'b1);
    chk("t4_csn",  csn_s[0], 1'b1);
    strobe_start(0, 8'h5A, 8'hC3);
    wait_rdy(0, 1'b0, low);
    chk("t4_low",  low, 32);
    chk("t4_recv2", recv_s[0], 8'hC3);
    chk("t4_mosi", cap0, 8'h5A);

    // 5: cs_wr ignored while busy, honoured while idle
    cs_wr_s[0] = 1'b1; cs_val_s[0] = 1'b0;
    cyc(1);
    cs_wr_s[0] = 1'b0;
    strobe_start(0, 8'h3C, 8'h42);
    cyc(3);
    cs_wr_s[0] = 1'b1; cs_val_s[0] = 1'b1;
    cyc(1);
    cs_wr_s[0] = 1'b0;
    chk("t5_busy_csn", csn_s[0], 1'b0);
    wait_rdy(0, 1'b0, low);
    cs_wr_s[0] = 1'b1; cs_val_s[0] = 1'b1;
    cyc(1);
    cs_wr_s[0] = 1'b0;
    chk("t5_idle_csn", csn_s[0], 1'b1);

    // 6: DIV=1
    strobe_start(1, 8'h81, 8'h7E);
    wait_rdy(1, 1'b0, low);
    chk("t6_low",  low, 16);
    chk("t6_recv", recv_s[1], 8'h7E);

    // Random exchanges with ignored strobes in flight and simultaneous start+cs_wr
    for (int n = 0; n < 40; n++) begin
      int         d;
      logic [7:0] tx, rx;
      d  = $urandom_range(0, 1);
      tx = 8'($urandom);
      rx = 8'($urandom);
      cyc($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        cs_wr_s[d] = 1'b1; cs_val_s[d] = 1'($urandom);
      end
      strobe_start(d, tx, rx);
      cs_wr_s[d] = 1'b0;
      wait_rdy(d, 1'b1, low);
      chk("rnd_low",  low, 16 * divof(d));
      chk("rnd_recv", recv_s[d], rx);
    end

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
